secuenciador_comparador: RTL and testbench

Controller that time-shares one date comparator (Comparador) across a bank of N stored product dates. On a start pulse it captures a reference date and walks the product register bank address by address. It feeds each stored dia/mes to the comparator and tallies the V result into vigente/vencido/no-valido counters. It also reports the index of the first expired product. It sits between the product registro bank and the comparator and is the only driver of the comparator inputs.

---
 rtl/secuenciador_comparador.sv | 157 +++++++++++++++
 tb/tb_secuenciador_comparador.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_comparador.sv
// Scan controller: walks the product bank through one shared date comparator
// and tallies vigente / vencido / no-valido results for a captured reference.
module secuenciador_comparador #(
  parameter int N_PROD = 8,
  parameter int AW     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inicio,
  input  logic [4:0]    diaRef_in,
  input  logic [3:0]    mesRef_in,
  output logic [AW-1:0] direccion,
  input  logic [4:0]    dia_reg,
  input  logic [3:0]    mes_reg,
  output logic [4:0]    dia,
  output logic [3:0]    mes,
  output logic [4:0]    diaRef,
  output logic [3:0]    mesRef,
  input  logic [1:0]    V,
  output logic          ocupado,
  output logic          listo,
  output logic [AW:0]   cnt_vigente,
  output logic [AW:0]   cnt_vencido,
  output logic [AW:0]   cnt_invalido,
  output logic          hay_vencido,
  output logic [AW-1:0] primer_vencido
);

  typedef enum logic [1:0] {
    IDLE,
    LEER,
    COMPARAR,
    FIN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N_PROD - 1);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] dir_q, dir_d;
  logic [4:0]    dref_q, dref_d;
  logic [3:0]    mref_q, mref_d;
  logic [AW:0]   vig_q, vig_d;
  logic [AW:0]   ven_q, ven_d;
  logic [AW:0]   inv_q, inv_d;
  logic          hay_q, hay_d;
  logic [AW-1:0] pri_q, pri_d;
  logic          ocup_q, ocup_d;
  logic          listo_q, listo_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    dref_d  = dref_q;
    mref_d  = mref_q;
    vig_d   = vig_q;
    ven_d   = ven_q;
    inv_d   = inv_q;
    hay_d   = hay_q;
    pri_d   = pri_q;
    ocup_d  = ocup_q;
    listo_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inicio) begin
          state_d = LEER;
          dref_d  = diaRef_in;
          mref_d  = mesRef_in;
          vig_d   = '0;
          ven_d   = '0;
          inv_d   = '0;
          hay_d   = 1'b0;
          pri_d   = '0;
          idx_d   = '0;
          dir_d   = '0;
          ocup_d  = 1'b1;
        end
      end
      LEER: begin
        state_d = COMPARAR;
      end
      COMPARAR: begin
        unique case (1'b1)
          (V == 2'b00): vig_d = vig_q + ONE;
          (V == 2'b01): begin
            ven_d = ven_q + ONE;
            if (!hay_q) begin
              hay_d = 1'b1;
              pri_d = idx_q;
            end
          end
          default: inv_d = inv_q + ONE;
        endcase
        if (idx_q == LAST) begin
          state_d = FIN;
          listo_d = 1'b1;
        end else begin
          // Address for the next entry is presented during LEER.
          idx_d   = idx_q + AW'(1);
          dir_d   = idx_q + AW'(1);
          state_d = LEER;
        end
      end
      FIN: begin
        state_d = IDLE;
        ocup_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir_q   <= '0;
      dref_q  <= '0;
      mref_q  <= '0;
      vig_q   <= '0;
      ven_q   <= '0;
      inv_q   <= '0;
      hay_q   <= 1'b0;
      pri_q   <= '0;
      ocup_q  <= 1'b0;
      listo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      dref_q  <= dref_d;
      mref_q  <= mref_d;
      vig_q   <= vig_d;
      ven_q   <= ven_d;
      inv_q   <= inv_d;
      hay_q   <= hay_d;
      pri_q   <= pri_d;
      ocup_q  <= ocup_d;
      listo_q <= listo_d;
    end
  end

  assign dia            = (state_q == COMPARAR) ? dia_reg : '0;
  assign mes            = (state_q == COMPARAR) ? mes_reg : '0;
  assign direccion      = dir_q;
  assign diaRef         = dref_q;
  assign mesRef         = mref_q;
  assign ocupado        = ocup_q;
  assign listo          = listo_q;
  assign cnt_vigente    = vig_q;
  assign cnt_vencido    = ven_q;
  assign cnt_invalido   = inv_q;
  assign hay_vencido    = hay_q;
  assign primer_vencido = pri_q;

endmodule

// File: tb/tb_secuenciador_comparador.sv
// Bench for secuenciador_comparador: bank + comparator environment,
// cycle-count reference model, directed and randomized scans.
module tb_secuenciador_comparador;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int LAT = 2 * N + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          inicio;
  logic [4:0]    diaRef_in;
  logic [3:0]    mesRef_in;
  logic [AW-1:0] direccion;
  logic [4:0]    dia_reg;
  logic [3:0]    mes_reg;
  logic [4:0]    dia;
  logic [3:0]    mes;
  logic [4:0]    diaRef;
  logic [3:0]    mesRef;
  logic [1:0]    V;
  logic          ocupado;
  logic          listo;
  logic [AW:0]   cnt_vigente;
  logic [AW:0]   cnt_vencido;
  logic [AW:0]   cnt_invalido;
  logic          hay_vencido;
  logic [AW-1:0] primer_vencido;

  int tests = 0;
  int fails = 0;

  logic [4:0] bank_dia [N];
  logic [3:0] bank_mes [N];

  secuenciador_comparador #(.N_PROD(N), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .inicio(inicio),
    .diaRef_in(diaRef_in),
    .mesRef_in(mesRef_in),
    .direccion(direccion),
    .dia_reg(dia_reg),
    .mes_reg(mes_reg),
    .dia(dia),
    .mes(mes),
    .diaRef(diaRef),
    .mesRef(mesRef),
    .V(V),
    .ocupado(ocupado),
    .listo(listo),
    .cnt_vigente(cnt_vigente),
    .cnt_vencido(cnt_vencido),
    .cnt_invalido(cnt_invalido),
    .hay_vencido(hay_vencido),
    .primer_vencido(primer_vencido)
  );

  always #5 clk = ~clk;

  function automatic int dim(input logic [3:0] m);
    case (m)
      4'd2: return 29;
      4'd4, 4'd6, 4'd9, 4'd11: return 30;
      default: return 31;
    endcase
  endfunction

  // Comparator environment; month 14 forces the 11 code.
  function automatic logic [1:0] cmp(
    input logic [4:0] d, input logic [3:0] m,
    input logic [4:0] dr, input logic [3:0] mr);
    if (m == 4'd14) return 2'b11;
    if (m < 4'd1 || m > 4'd12) return 2'b10;
    if (d < 5'd1 || int'(d) > dim(m)) return 2'b10;
    if ({m, d} > {mr, dr}) return 2'b00;
    return 2'b01;
  endfunction

  assign V = cmp(dia, mes, diaRef, mesRef);

  always @(posedge clk) begin
    dia_reg <= bank_dia[direccion];
    mes_reg <= bank_mes[direccion];
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected scan result for the current bank and reference inputs.
  int t_vig, t_ven, t_inv, t_hay, t_pri;
  always_comb begin
    t_vig = 0;
    t_ven = 0;
    t_inv = 0;
    t_hay = 0;
    t_pri = 0;
    for (int i = 0; i < N; i++) begin
      case (cmp(bank_dia[i], bank_mes[i], diaRef_in, mesRef_in))
        2'b00: t_vig = t_vig + 1;
        2'b01: begin
          t_ven = t_ven + 1;
          if (t_hay == 0) begin
            t_hay = 1;
            t_pri = i;
          end
        end
        default: t_inv = t_inv + 1;
      endcase
    end
  end

  // k = cycles since the accepted start (0 when idle).
  int k = 0;
  int e_dir = 0, e_dref = 0, e_mref = 0;
  int e_vig = 0, e_ven = 0, e_inv = 0, e_hay = 0, e_pri = 0;

  always @(posedge clk) begin
    if (reset) begin
      k <= 0;
      e_dir <= 0; e_dref <= 0; e_mref <= 0;
      e_vig <= 0; e_ven <= 0; e_inv <= 0;
      e_hay <= 0; e_pri <= 0;
    end else if (k == 0) begin
      if (inicio) begin
        k <= 1;
        e_dir <= 0;
        e_dref <= int'(diaRef_in);
        e_mref <= int'(mesRef_in);
        e_vig <= t_vig; e_ven <= t_ven; e_inv <= t_inv;
        e_hay <= t_hay; e_pri <= t_pri;
      end
    end else if (k == LAT) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if ((k + 1) % 2 == 1 && k + 1 < LAT) e_dir <= k / 2;
    end
  end

  always @(negedge clk) begin
    chk("ocupado", int'(ocupado), int'(k >= 1 && k <= LAT));
    chk("listo", int'(listo), int'(k == LAT));
    chk("direccion", int'(direccion), e_dir);
    if (k >= 2 && k <= 2 * N && k % 2 == 0) begin
      chk("dia", int'(dia), int'(bank_dia[(k-2)/2]));
      chk("mes", int'(mes), int'(bank_mes[(k-2)/2]));
    end else begin
      chk("dia_zero", int'(dia), 0);
      chk("mes_zero", int'(mes), 0);
    end
    chk("diaRef", int'(diaRef), e_dref);
    chk("mesRef", int'(mesRef), e_mref);
    if (k == 0 || k == LAT) begin
      chk("cnt_vigente", int'(cnt_vigente), e_vig);
      chk("cnt_vencido", int'(cnt_vencido), e_ven);
      chk("cnt_invalido", int'(cnt_invalido), e_inv);
      chk("hay_vencido", int'(hay_vencido), e_hay);
      chk("primer_vencido", int'(primer_vencido), e_pri);
    end
  end

  task automatic set_entry(input int i, input int d, input int m);
    bank_dia[i] = 5'(d);
    bank_mes[i] = 4'(m);
  endtask

  task automatic basic_bank();
    set_entry(0, 14, 4);
    set_entry(1, 1, 1);
    set_entry(2, 30, 2);
    set_entry(3, 22, 2);
  endtask

  task automatic run_scan(input int dr, input int mr, output int lat);
    @(posedge clk);
    #1;
    diaRef_in = 5'(dr);
    mesRef_in = 4'(mr);
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (listo) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pin(input string nm, input int vg, input int ve,
                     input int iv, input int h, input int p);
    chk({nm, "_vig"}, int'(cnt_vigente), vg);
    chk({nm, "_ven"}, int'(cnt_vencido), ve);
    chk({nm, "_inv"}, int'(cnt_invalido), iv);
    chk({nm, "_hay"}, int'(hay_vencido), h);
    chk({nm, "_pri"}, int'(primer_vencido), p);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nl, no, r;
    reset = 1'b1;
    inicio = 1'b0;
    diaRef_in = '0;
    mesRef_in = '0;
    basic_bank();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    pin("reset", 0, 0, 0, 0, 0);
    chk("reset_ocupado", int'(ocupado), 0);

    run_scan(22, 2, lat);
    chk("basic_latency", lat, 9);
    pin("basic", 1, 2, 1, 1, 1);

    run_scan(27, 7, lat);
    chk("b2b_latency", lat, 9);
    pin("b2b", 0, 3, 1, 1, 0);

    for (int i = 0; i < N; i++) set_entry(i, 31, 15);
    run_scan(16, 1, lat);
    pin("allinv", 0, 0, 4, 0, 0);
    set_entry(2, 31, 14);
    run_scan(16, 1, lat);
    pin("v11", 0, 0, 4, 0, 0);

    for (int i = 0; i < 3; i++) set_entry(i, 14, 4);
    set_entry(3, 22, 2);
    run_scan(22, 2, lat);
    pin("equal", 3, 1, 0, 1, 3);

    // Start requests and reference changes while busy.
    basic_bank();
    @(posedge clk);
    #1;
    diaRef_in = 5'd22;
    mesRef_in = 4'd2;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    nl = 0;
    no = 0;
    for (int c = 1; c <= 12; c++) begin
      inicio = (c == 3 || c == LAT);
      if (c == 2) begin
        diaRef_in = 5'd7;
        mesRef_in = 4'd12;
      end
      @(negedge clk);
      if (listo) begin
        nl++;
        pin("ignore", 1, 2, 1, 1, 1);
      end
      if (ocupado) no++;
      @(posedge clk);
      #1;
    end
    inicio = 1'b0;
    chk("ignore_listo_count", nl, 1);
    chk("ignore_ocupado_len", no, 9);

    // Abort mid-scan.
    @(posedge clk);
    #1;
    diaRef_in = 5'd22;
    mesRef_in = 4'd2;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    nl = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) reset = 1'b1;
      @(negedge clk);
      if (listo) nl++;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (listo) nl++;
    chk("abort_listo", nl, 0);
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_dir", int'(direccion), 0);
    chk("abort_diaRef", int'(diaRef), 0);
    chk("abort_mesRef", int'(mesRef), 0);
    pin("abort", 0, 0, 0, 0, 0);
    run_scan(22, 2, lat);
    chk("after_abort_latency", lat, 9);
    pin("after_abort", 1, 2, 1, 1, 1);

    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N; i++) begin
        bank_dia[i] = 5'($urandom_range(0, 31));
        if ($urandom % 4 == 0) bank_mes[i] = 4'($urandom_range(0, 15));
        else bank_mes[i] = 4'($urandom_range(1, 12));
      end
      r = (s % 7 == 3) ? int'($urandom_range(1, LAT)) : 0;
      run_scan($urandom_range(1, 31), $urandom_range(1, 12), lat);
      if (r == 0) chk("rand_latency", lat, 9);
      @(posedge clk);
      #1;
      for (int c = 0; c < LAT; c++) begin
        inicio = ($urandom % 4 == 0);
        diaRef_in = 5'($urandom);
        mesRef_in = 4'($urandom);
        reset = (r != 0 && c == r - 1);
        @(posedge clk);
        #1;
      end
      inicio = 1'b0;
      reset = 1'b0;
      repeat (2 * LAT) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
